axi_ram_slave: RTL and testbench
================================

# axi_ram_slave

Single-port-memory AXI3 slave that sits directly downstream of the CPU AXI bridge and serves its single-beat instruction and data reads and writes. Read and write paths are independent state machines sharing one word-organised memory with byte-strobed writes. It is the memory model behind the bridge in SoC simulation and FPGA bring-up. Read latency is configurable. An optional ready-throttling feature stresses the bridge's handshakes.

## Interface
- ADDR_WIDTH, 16, word-address bits; memory depth 2^ADDR_WIDTH × 32 bit
- READ_LATENCY, 1, cycles from AR handshake to first rvalid; legal range 1..15
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  4/32/8/3/2/2/4/3  read address
- arvalid  in  1; arready  out  1
- rid  out  4; rdata  out  32; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  4/32/8/3/2/2/4/3  write address
- awvalid  in  1; awready  out  1
- wid  in  4; wdata  in  32; wstrb  in  4; wlast  in  1; wvalid  in  1; wready  out  1
- bid  out  4; bresp  out  2; bvalid  out  1; bready  in  1

## Operation
- Single-beat only: arlen, awlen, arsize, awsize, burst, lock, cache and prot are ignored. rlast is always 1. rresp and bresp are always 2'b00 (OKAY). wid and wlast are ignored.
- Word index = addr[ADDR_WIDTH+1:2]. Upper bits alias; addr[1:0] is ignored. wstrb[i] writes byte i.
- Read FSM R_IDLE → R_WAIT → R_RESP:
  - R_IDLE: arready=1. On AR handshake, latch arid and the word index, load counter=READ_LATENCY-1, go to R_WAIT. If READ_LATENCY=1, go straight to R_RESP.
  - R_WAIT: decrement the counter. When it reaches 0, go to R_RESP.
  - On entry to R_RESP, rdata is captured from memory. rvalid=1, rid=latched arid, and rdata is held stable until the R handshake, then return to R_IDLE.
- Write FSM W_IDLE → W_DATA → W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch awid and the index, go to W_DATA.
  - W_DATA: wready=1. On W handshake, commit the strobed bytes, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched awid. On B handshake, go to W_IDLE.
- W is never accepted before AW: wready=0 outside W_DATA.
- Read and write FSMs run concurrently and never block each other.
- Same-cycle read capture and write commit to the same word: rdata returns the pre-write value.

## Timing
- Reset values: rvalid=0, bvalid=0, wready=0, rid=0, bid=0, rdata=0, rlast=1, rresp=0, bresp=0. arready=1 and awready=1, because both FSMs sit in IDLE. Masters must hold valid low during reset.
- Memory contents are not reset.
- Read: AR handshake in cycle 0 → rvalid high in cycle READ_LATENCY. With rready held high, the next arready is in cycle READ_LATENCY+1.
- Write: AW handshake in cycle 0 → wready high in cycle 1. W handshake in cycle k → bvalid in cycle k+1. With bready held high, awready returns in cycle k+2.
- Handshake rules:
  - Valid outputs hold until accepted.
  - Ready outputs are pure decodes of FSM state (plus the throttle mask when enabled); they are never combinational on an input valid.
- Reset mid-transaction: all in-flight transactions are dropped without response. FSMs return to IDLE on the next edge. Memory is preserved.

## Configuration
- AXI_RAM_RAND_DELAY_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reset to the seed) advances every cycle.
  - arready, awready and wready are each ANDed with LFSR bits 0, 1 and 2 respectively.
  - Handshakes occur only when the masked ready is 1. FSM behaviour is otherwise unchanged.
- Undefined: no LFSR is instantiated; readies follow FSM state only.

## Structure
- Package axi_ram_pkg holds:
  - the read and write state enums;
  - RESP_OKAY=2'b00;
  - LFSR_SEED=16'hACE1 and the LFSR tap mask.
- Sub-module axi_ram_lfsr, instantiated only under AXI_RAM_RAND_DELAY_EN.

## Test plan
- Write then read back, READ_LATENCY=1:
  - Stimulus: AW 0x100 id 1, then W 0xDEADBEEF with wstrb 4'hF.
  - Required: bvalid one cycle after the W handshake, bid=1.
  - Then AR 0x100 id 0 → rvalid one cycle later, rdata=0xDEADBEEF, rid=0, rlast=1.
- Byte strobes:
  - Stimulus: write 0x11223344 to 0x200, then write 0xAABBCCDD with wstrb 4'b0101.
  - Required: a read of 0x200 returns 0x11BB33DD.
- Latency:
  - Stimulus: READ_LATENCY=4, AR in cycle 0.
  - Required: rvalid first high in cycle 4. With rready held low for 3 cycles, rdata is stable and arready stays 0.
- Concurrency:
  - Stimulus: AR 0x300 and AW 0x300 accepted in the same cycle, with W committing on the read-capture edge.
  - Required: read returns the old value; a later read returns the new value.
- Reset mid-transaction:
  - Stimulus: assert resetn low while in R_RESP and W_DATA.
  - Required: the next cycle shows rvalid=0, wready=0, arready=1, awready=1; previously written memory still reads correctly.
- With AXI_RAM_RAND_DELAY_EN: 1000 random single-beat reads and writes complete with no protocol violation and data matching a scoreboard.

Source files
------------

// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI3 single-beat RAM slave:
// read/write FSM state encodings, response code and ready-throttle LFSR setup.
package axi_ram_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } r_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   localparam logic [1:0]  RESP_OKAY = 2'b00;

   // Fibonacci LFSR with taps 16,14,13,11 -> state bits 15,13,12,10.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One LFSR step: shift left, feedback is the XOR of the tapped bits.
   function automatic logic [15:0] lfsr_next(input logic [15:0] state);
      return {state[14:0], ^(state & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/axi_ram_lfsr.sv
// Free-running 16-bit LFSR used to throttle the slave's ready outputs.
// Exposes only the three low bits that mask arready/awready/wready.
module axi_ram_lfsr
   import axi_ram_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   output logic [2:0] mask
);

   logic [15:0] state;

   // Advance the LFSR every cycle; restart from the seed on reset.
   always_ff @(posedge clk) begin
      if (!resetn) state <= LFSR_SEED;
      else         state <= lfsr_next(state);
   end

   assign mask = state[2:0];

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 single-beat RAM slave: independent read and write FSMs sharing one
// word-organised memory with byte-strobed writes and configurable read latency.
// Define AXI_RAM_RAND_DELAY_EN to throttle arready/awready/wready with an LFSR.
module axi_ram_slave
   import axi_ram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   // read address
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   // read data
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   // write address
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   // write data
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   // write response
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

   logic [31:0]           mem [DEPTH];
   r_state_t              r_state;
   w_state_t              w_state;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [3:0]            r_cnt;
   logic [2:0]            ready_mask;
   logic                  ar_hs;
   logic                  aw_hs;
   logic                  w_hs;
   logic [ADDR_WIDTH-1:0] ar_idx;
   logic [ADDR_WIDTH-1:0] aw_idx;

`ifdef AXI_RAM_RAND_DELAY_EN
   axi_ram_lfsr u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .mask   (ready_mask)
   );
`else
   assign ready_mask = 3'b111;
`endif

   // Readies decode FSM state only, so they never depend on an input valid.
   assign arready = (r_state == R_IDLE) & ready_mask[0];
   assign awready = (w_state == W_IDLE) & ready_mask[1];
   assign wready  = (w_state == W_DATA) & ready_mask[2];

   assign ar_hs  = arvalid & arready;
   assign aw_hs  = awvalid & awready;
   assign w_hs   = wvalid & wready;

   // Upper address bits alias and the byte offset is ignored.
   assign ar_idx = araddr[ADDR_WIDTH+1:2];
   assign aw_idx = awaddr[ADDR_WIDTH+1:2];

   assign rlast  = 1'b1;
   assign rresp  = RESP_OKAY;
   assign bresp  = RESP_OKAY;

   // Read FSM: accept AR, count down the latency, present data until R handshake.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; this is also what makes a same-edge read return old data.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= R_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         rid     <= '0;
         rdata   <= '0;
         rvalid  <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rid   <= arid;
                  r_idx <= ar_idx;
                  r_cnt <= LAT_LOAD;
                  if (READ_LATENCY == 1) begin
                     rdata   <= mem[ar_idx];
                     rvalid  <= 1'b1;
                     r_state <= R_RESP;
                  end else begin
                     r_state <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  rdata   <= mem[r_idx];
                  rvalid  <= 1'b1;
                  r_state <= R_RESP;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rvalid  <= 1'b0;
                  r_state <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Write FSM: accept AW, then exactly one W beat, then hold B until accepted.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         w_state <= W_IDLE;
         w_idx   <= '0;
         bid     <= '0;
         bvalid  <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  bid     <= awid;
                  w_idx   <= aw_idx;
                  w_state <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  bvalid  <= 1'b1;
                  w_state <= W_RESP;
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Commit strobed bytes on the W handshake; writes in flight at reset are dropped.
   // NOTE: the memory array has no reset so contents survive resetn and it can
   // map onto block RAM.
   always_ff @(posedge clk) begin
      if (resetn && w_hs) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Single-beat slave: burst/size/attribute fields and the unused address bits
   // are intentionally ignored.
   logic unused_ok;
   assign unused_ok = ^{arlen, arsize, arburst, arlock, arcache, arprot,
                        awlen, awsize, awburst, awlock, awcache, awprot,
                        wid, wlast, araddr[1:0], awaddr[1:0],
                        araddr[31:ADDR_WIDTH+2], awaddr[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: two instances (read latency 1 and 4),
// scoreboard queues for R and B responses, and a short random phase.
module tb_axi_ram_slave;

   localparam int BUD = 64;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  arid    [2];
   logic [31:0] araddr  [2];
   logic        arvalid [2];
   logic        arready [2];
   logic [3:0]  rid     [2];
   logic [31:0] rdata   [2];
   logic [1:0]  rresp   [2];
   logic        rlast   [2];
   logic        rvalid  [2];
   logic        rready  [2];
   logic [3:0]  awid    [2];
   logic [31:0] awaddr  [2];
   logic        awvalid [2];
   logic        awready [2];
   logic [31:0] wdata   [2];
   logic [3:0]  wstrb   [2];
   logic        wvalid  [2];
   logic        wready  [2];
   logic [3:0]  bid     [2];
   logic [1:0]  bresp   [2];
   logic        bvalid  [2];
   logic        bready  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axi_ram_slave #(
         .ADDR_WIDTH   (16),
         .READ_LATENCY ((g == 0) ? 1 : 4)
      ) dut (
         .clk     (clk),
         .resetn  (resetn),
         .arid    (arid[g]),
         .araddr  (araddr[g]),
         .arlen   (8'd0),
         .arsize  (3'd2),
         .arburst (2'd1),
         .arlock  (2'd0),
         .arcache (4'd0),
         .arprot  (3'd0),
         .arvalid (arvalid[g]),
         .arready (arready[g]),
         .rid     (rid[g]),
         .rdata   (rdata[g]),
         .rresp   (rresp[g]),
         .rlast   (rlast[g]),
         .rvalid  (rvalid[g]),
         .rready  (rready[g]),
         .awid    (awid[g]),
         .awaddr  (awaddr[g]),
         .awlen   (8'd0),
         .awsize  (3'd2),
         .awburst (2'd1),
         .awlock  (2'd0),
         .awcache (4'd0),
         .awprot  (3'd0),
         .awvalid (awvalid[g]),
         .awready (awready[g]),
         .wid     (4'd0),
         .wdata   (wdata[g]),
         .wstrb   (wstrb[g]),
         .wlast   (1'b1),
         .wvalid  (wvalid[g]),
         .wready  (wready[g]),
         .bid     (bid[g]),
         .bresp   (bresp[g]),
         .bvalid  (bvalid[g]),
         .bready  (bready[g])
      );
   end

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
   } rexp_t;

   rexp_t       rq [$];
   logic [3:0]  bq [$];
   logic [31:0] model [int];
   int          n_cmp  = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   function automatic int key(input int d, input logic [31:0] a);
      logic [15:0] idx;
      idx = a[17:2];
      return d * 65536 + int'(idx);
   endfunction

   task automatic model_wr(input int d, input logic [31:0] a, input logic [31:0] data,
                           input logic [3:0] strb);
      logic [31:0] cur;
      int          k;
      k   = key(d, a);
      cur = model.exists(k) ? model[k] : 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) cur[8*i +: 8] = data[8*i +: 8];
      end
      model[k] = cur;
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         arid[d] = '0; araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
         awid[d] = '0; awaddr[d] = '0; awvalid[d] = 1'b0;
         wdata[d] = '0; wstrb[d] = '0; wvalid[d] = 1'b0; bready[d] = 1'b0;
      end
   endtask

   task automatic axi_write(input int d, input logic [31:0] a, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] id);
      int n;
      awaddr[d] = a; awid[d] = id; awvalid[d] = 1'b1;
      n = 0;
      while (!awready[d] && n < BUD) begin tick(); n++; end
      check("aw_ready", 32'(awready[d]), 32'd1);
      tick();
      awvalid[d] = 1'b0;
      check("w_ready_after_aw", 32'(wready[d]), 32'd1);
      bq.push_back(id);
      model_wr(d, a, data, strb);
      wdata[d] = data; wstrb[d] = strb; wvalid[d] = 1'b1;
      n = 0;
      while (!wready[d] && n < BUD) begin tick(); n++; end
      tick();
      wvalid[d] = 1'b0;
      check("b_valid_after_w", 32'(bvalid[d]), 32'd1);
      check("bid", 32'(bid[d]), 32'(bq.pop_front()));
      check("bresp", 32'(bresp[d]), 32'd0);
      bready[d] = 1'b1;
      tick();
      bready[d] = 1'b0;
      check("aw_ready_back", 32'(awready[d]), 32'd1);
   endtask

   task automatic axi_read(input int d, input logic [31:0] a, input logic [3:0] id,
                           input int hold, output logic [31:0] got);
      int    n;
      rexp_t e;
      e.id   = id;
      e.data = model[key(d, a)];
      rq.push_back(e);
      araddr[d] = a; arid[d] = id; arvalid[d] = 1'b1;
      n = 0;
      while (!arready[d] && n < BUD) begin tick(); n++; end
      check("ar_ready", 32'(arready[d]), 32'd1);
      tick();
      arvalid[d] = 1'b0;
      n = 1;
      while (!rvalid[d] && n < BUD) begin tick(); n++; end
      check("r_latency", 32'(n), 32'(lat(d)));
      for (int i = 0; i < hold; i++) begin
         check("r_hold_valid", 32'(rvalid[d]), 32'd1);
         check("r_hold_data", rdata[d], rq[0].data);
         check("r_hold_arready", 32'(arready[d]), 32'd0);
         tick();
      end
      e = rq.pop_front();
      check("rdata", rdata[d], e.data);
      check("rid", 32'(rid[d]), 32'(e.id));
      check("rlast", 32'(rlast[d]), 32'd1);
      check("rresp", 32'(rresp[d]), 32'd0);
      got = rdata[d];
      rready[d] = 1'b1;
      tick();
      rready[d] = 1'b0;
      check("ar_ready_back", 32'(arready[d]), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] got;
      rexp_t       e;

      idle_all();
      resetn = 1'b0;
      repeat (3) tick();

      // Reset state of both instances.
      for (int d = 0; d < 2; d++) begin
         check("rst_rvalid",  32'(rvalid[d]),  32'd0);
         check("rst_bvalid",  32'(bvalid[d]),  32'd0);
         check("rst_wready",  32'(wready[d]),  32'd0);
         check("rst_rid",     32'(rid[d]),     32'd0);
         check("rst_bid",     32'(bid[d]),     32'd0);
         check("rst_rdata",   rdata[d],        32'd0);
         check("rst_rlast",   32'(rlast[d]),   32'd1);
         check("rst_rresp",   32'(rresp[d]),   32'd0);
         check("rst_bresp",   32'(bresp[d]),   32'd0);
         check("rst_arready", 32'(arready[d]), 32'd1);
         check("rst_awready", 32'(awready[d]), 32'd1);
      end
      resetn = 1'b1;
      tick();

      // Write then read back, latency 1.
      axi_write(0, 32'h100, 32'hDEADBEEF, 4'hF, 4'd1);
      axi_read(0, 32'h100, 4'd0, 0, got);
      check("wr_rd_100", got, 32'hDEADBEEF);

      // Byte strobes.
      axi_write(0, 32'h200, 32'h11223344, 4'hF, 4'd2);
      axi_write(0, 32'h200, 32'hAABBCCDD, 4'b0101, 4'd3);
      axi_read(0, 32'h200, 4'd4, 0, got);
      check("strobe_200", got, 32'h11BB33DD);

      // Address aliasing: upper bits and byte offset ignored.
      axi_write(0, 32'h0004_0500, 32'h5A5A0F0F, 4'hF, 4'd5);
      axi_read(0, 32'h0000_0503, 4'd6, 0, got);
      check("alias_500", got, 32'h5A5A0F0F);

      // Latency 4 with rready held low for 3 cycles.
      axi_write(1, 32'h40, 32'hCAFEF00D, 4'hF, 4'd4);
      axi_read(1, 32'h40, 4'd5, 3, got);
      check("lat4_data", got, 32'hCAFEF00D);

      // Concurrency: AR and AW together, W commits on the read-capture edge.
      axi_write(1, 32'h300, 32'h01234567, 4'hF, 4'd6);
      e.id   = 4'd2;
      e.data = 32'h01234567;
      rq.push_back(e);
      bq.push_back(4'd3);
      araddr[1] = 32'h300; arid[1] = 4'd2; arvalid[1] = 1'b1;
      awaddr[1] = 32'h300; awid[1] = 4'd3; awvalid[1] = 1'b1;
      check("cc_arready", 32'(arready[1]), 32'd1);
      check("cc_awready", 32'(awready[1]), 32'd1);
      tick();
      arvalid[1] = 1'b0; awvalid[1] = 1'b0;
      check("cc_wready", 32'(wready[1]), 32'd1);
      wdata[1] = 32'h89ABCDEF; wstrb[1] = 4'hF;
      tick();
      tick();
      wvalid[1] = 1'b1;
      check("cc_rvalid_pre", 32'(rvalid[1]), 32'd0);
      tick();
      wvalid[1] = 1'b0;
      e = rq.pop_front();
      check("cc_rvalid", 32'(rvalid[1]), 32'd1);
      check("cc_rdata_old", rdata[1], e.data);
      check("cc_rid", 32'(rid[1]), 32'(e.id));
      check("cc_bvalid", 32'(bvalid[1]), 32'd1);
      check("cc_bid", 32'(bid[1]), 32'(bq.pop_front()));
      model_wr(1, 32'h300, 32'h89ABCDEF, 4'hF);
      rready[1] = 1'b1; bready[1] = 1'b1;
      tick();
      rready[1] = 1'b0; bready[1] = 1'b0;
      axi_read(1, 32'h300, 4'd7, 0, got);
      check("cc_rdata_new", got, 32'h89ABCDEF);

      // Reset with instance 0 in R_RESP and W_DATA.
      araddr[0] = 32'h100; arid[0] = 4'd7; arvalid[0] = 1'b1;
      awaddr[0] = 32'h100; awid[0] = 4'd8; awvalid[0] = 1'b1;
      tick();
      arvalid[0] = 1'b0; awvalid[0] = 1'b0;
      check("mid_rvalid", 32'(rvalid[0]), 32'd1);
      check("mid_wready", 32'(wready[0]), 32'd1);
      resetn = 1'b0;
      tick();
      check("rr_rvalid",  32'(rvalid[0]),  32'd0);
      check("rr_wready",  32'(wready[0]),  32'd0);
      check("rr_arready", 32'(arready[0]), 32'd1);
      check("rr_awready", 32'(awready[0]), 32'd1);
      resetn = 1'b1;
      rq.delete();
      bq.delete();
      tick();
      axi_read(0, 32'h100, 4'd9, 0, got);
      check("rr_mem_100", got, 32'hDEADBEEF);
      axi_read(0, 32'h200, 4'd10, 0, got);
      check("rr_mem_200", got, 32'h11BB33DD);

      // Random single-beat traffic against the scoreboard.
      for (int i = 0; i < 8; i++) begin
         axi_write(0, 32'h1000 + 32'(i * 4), $urandom, 4'hF, 4'(i));
      end
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = 32'h1000 + 32'($urandom_range(7) * 4);
         if ($urandom_range(1) == 1)
            axi_write(0, a, $urandom, 4'($urandom_range(15)), 4'($urandom_range(15)));
         else
            axi_read(0, a, 4'($urandom_range(15)), $urandom_range(2), got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
